sum_window_avg: RTL and testbench
=================================

# sum_window_avg

Downstream consumer of the three-operand `sum` adder: samples its 6-bit result on a valid strobe and maintains a sliding-window total and average over the last 2**DEPTH_LOG2 accepted samples. Provides a smoothed value for display and threshold logic further down the datapath. There is no backpressure; the adder output is combinational and always available, so the block accepts one sample per qualified cycle.

## Interface

- DEPTH_LOG2, 2, log2 of window length N (N = 4 by default); legal range 1..4
- IN_W, 6, input sample width; matches the adder output width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  sample strobe; in_data is accepted on every rising edge where in_valid = 1
- in_data  input  IN_W  sum from the adder (0..45 in the default system)
- clear  input  1  synchronous flush of window contents and state
- out_valid  output  1  one-cycle pulse: out_sum and out_avg were updated by a sample taken while the window was full
- out_sum  output  IN_W+DEPTH_LOG2  total of the last N accepted samples
- out_avg  output  IN_W  out_sum >> DEPTH_LOG2, truncated
- full  output  1  window holds N valid samples

## Operation

- Storage: N-entry shift register, entry 0 newest, entry N-1 oldest; fill counter 0..N.
- On accept: shift in in_data; total <= total + in_data - entry[N-1]. Entries are zero after reset or clear, so no special case applies during fill.
- Width: total is IN_W+DEPTH_LOG2 bits and cannot overflow (N × (2**IN_W−1) fits). The subtraction is done at full total width and never goes negative.
- FSM:
  - FILL: counter < N; each accept increments the counter. The accept that brings the counter to N moves to RUN.
  - RUN: counter = N; counter is held.
  - clear returns the FSM to FILL from either state.
- out_valid = 1 for exactly one cycle after every accept that leaves the block in RUN, including the accept that completes the fill. It is 0 for all other accepts.
- out_sum and out_avg track the registered total at all times, including during FILL, but are qualified only by out_valid.
- clear together with in_valid: clear wins and the sample is dropped. All entries, total and counter go to 0, out_valid = 0 next cycle.
- in_valid = 0 cycles: all state and outputs hold; out_valid = 0.

## Timing

- Latency 1 cycle: a sample accepted at edge k is reflected in out_sum, out_avg and out_valid after edge k.
- Throughput: one sample per cycle, sustained.
- Reset values (rst_n low, asynchronous): all entries 0, total 0, counter 0, FSM FILL, out_valid 0, out_sum 0, out_avg 0, full 0.
- Reset deassertion is synchronised externally; the first accept can occur on the first edge with rst_n high.
- Reset mid-operation discards all samples. The window restarts from empty, and the first out_valid comes N accepts after release.
- full is registered and asserted in the same cycle as the first out_valid.

## Structure

- Package sum_pkg:
  - localparam SUM_W = 6
  - localparam OPND_W = 4
  - enum typedef win_state_t {FILL, RUN}
  - shared by sum, this block and benches
- Sub-module window_shreg:
  - parameterised N × IN_W shift register with enable and synchronous clear
  - exposes the oldest entry combinationally
  - flushed to zero by rst_n
- Top module holds the FSM, fill counter, total register and output logic (about 150–200 lines total).

## Test plan

- Fill: reset, accept 10, 20, 30, 40 on consecutive cycles:
  - out_valid low after the first three accepts
  - after the 4th: out_valid = 1, out_sum = 100, out_avg = 25, full = 1
- Slide: continue from the fill case, accept 45 -> out_sum = 135, out_avg = 33, out_valid = 1. Then accept 45 three more times -> out_sum = 180, out_avg = 45 (maximum, no overflow).
- Gaps: in RUN, drop in_valid for 3 cycles:
  - out_valid = 0
  - out_sum and out_avg unchanged
  - next accept of 0 removes the oldest sample correctly (180 -> 135)
- Clear collision: assert clear and in_valid together with in_data = 45:
  - next cycle out_sum = 0, full = 0, out_valid = 0
  - next 4 accepts of 1 -> out_sum = 4, out_avg = 1 on the 4th
- Async reset mid-run: pull rst_n low between clock edges. All outputs are 0 immediately, without waiting for an edge. After release, the first out_valid occurs only after 4 accepts.
- Random: drive `sum` with random 4-bit a, b, c and random in_valid; a scoreboard compares out_sum and out_avg against a reference model of the last 4 sums on every out_valid.

Source files
------------

// File: rtl/sum_pkg.sv
// sum_pkg: widths and state encoding shared by the adder, the window averager and benches.
// Revision: 1.0
`default_nettype none

package sum_pkg;

  localparam int SUM_W  = 6;
  localparam int OPND_W = 4;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_t;

endpackage

`default_nettype wire

// File: rtl/window_shreg.sv
// window_shreg: DEPTH x WIDTH shift register, entry 0 newest, oldest entry exposed combinationally.
// Revision: 1.0
`default_nettype none

module window_shreg
  import sum_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = SUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] oldest
);

  logic [WIDTH-1:0] entries [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (en) begin
      entries[0] <= din;
      for (int i = 1; i < DEPTH; i++) entries[i] <= entries[i-1];
    end
  end

  assign oldest = entries[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/sum_window_avg.sv
// sum_window_avg: sliding-window total and truncated average over the last 2**DEPTH_LOG2 samples.
// Revision: 1.0
`default_nettype none

module sum_window_avg
  import sum_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int IN_W       = SUM_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       clear,
  output logic                       out_valid,
  output logic [IN_W+DEPTH_LOG2-1:0] out_sum,
  output logic [IN_W-1:0]            out_avg,
  output logic                       full
);

  localparam int N     = 1 << DEPTH_LOG2;
  localparam int TOT_W = IN_W + DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);

  win_state_t       state;
  logic [CNT_W-1:0] count;
  logic [TOT_W-1:0] total;
  logic [IN_W-1:0]  oldest;
  logic             accept;

  assign accept = in_valid && !clear;

  window_shreg #(
    .DEPTH (N),
    .WIDTH (IN_W)
  ) u_shreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (accept),
    .clr    (clear),
    .din    (in_data),
    .oldest (oldest)
  );

  // Entries are zero until overwritten, so the same update works during fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      count     <= '0;
      total     <= '0;
      out_valid <= 1'b0;
      full      <= 1'b0;
    end else if (clear) begin
      state     <= FILL;
      count     <= '0;
      total     <= '0;
      out_valid <= 1'b0;
      full      <= 1'b0;
    end else if (in_valid) begin
      total <= total + TOT_W'(in_data) - TOT_W'(oldest);
      case (state)
        FILL: begin
          if (count == CNT_LAST) begin
            count     <= CNT_FULL;
            state     <= RUN;
            full      <= 1'b1;
            out_valid <= 1'b1;
          end else begin
            count     <= count + CNT_W'(1);
            out_valid <= 1'b0;
          end
        end
        RUN: begin
          out_valid <= 1'b1;
        end
        default: begin
          state     <= FILL;
          out_valid <= 1'b0;
        end
      endcase
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign out_sum = total;
  assign out_avg = total[TOT_W-1:DEPTH_LOG2];

endmodule

`default_nettype wire

// File: tb/tb_sum_window_avg.sv
// tb_sum_window_avg: table vectors, hand sequences and a random scoreboard run for sum_window_avg.
// Revision: 1.0
`default_nettype none

module tb_sum_window_avg;
  import sum_pkg::*;

  localparam int N = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [SUM_W-1:0] in_data;
  logic             clear;
  logic             out_valid;
  logic [7:0]       out_sum;
  logic [5:0]       out_avg;
  logic             full;

  sum_window_avg #(
    .DEPTH_LOG2 (2),
    .IN_W       (SUM_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_avg   (out_avg),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: last N accepted samples, newest first.
  int hist [N];
  int fill_cnt;
  bit exp_valid;
  typedef struct {int s; int a;} sb_t;
  sb_t sbq [$];

  typedef struct {
    bit       v;
    bit       c;
    bit [5:0] d;
    bit       ev;
    int       es;
    int       ea;
    bit       ef;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) hist[i] = 0;
    fill_cnt  = 0;
    exp_valid = 0;
    sbq.delete();
  endtask

  task automatic model_edge(input bit v, input bit c, input int d);
    int s;
    if (c) begin
      for (int i = 0; i < N; i++) hist[i] = 0;
      fill_cnt  = 0;
      exp_valid = 0;
    end else if (v) begin
      for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = d;
      if (fill_cnt < N) fill_cnt++;
      exp_valid = (fill_cnt == N);
      if (exp_valid) begin
        s = 0;
        for (int i = 0; i < N; i++) s += hist[i];
        sbq.push_back('{s: s, a: s / N});
      end
    end else begin
      exp_valid = 0;
    end
  endtask

  // One clock: drive after the falling edge, update the model at the rising edge, check 1ns later.
  task automatic step(input bit v, input bit c, input int d);
    sb_t e;
    @(negedge clk);
    in_valid = v;
    clear    = c;
    in_data  = 6'(d);
    @(posedge clk);
    model_edge(v, c, d);
    #1;
    chk("out_valid", int'(out_valid), int'(exp_valid));
    if (out_valid) begin
      if (sbq.size() == 0) begin
        chk("scoreboard_nonempty", 0, 1);
      end else begin
        e = sbq.pop_front();
        chk("sb_sum", int'(out_sum), e.s);
        chk("sb_avg", int'(out_avg), e.a);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 0, 10, 0, 10,  2,  0};
    tbl[1]  = '{1, 0, 20, 0, 30,  7,  0};
    tbl[2]  = '{1, 0, 30, 0, 60,  15, 0};
    tbl[3]  = '{1, 0, 40, 1, 100, 25, 1};
    tbl[4]  = '{1, 0, 45, 1, 135, 33, 1};
    tbl[5]  = '{1, 0, 45, 1, 160, 40, 1};
    tbl[6]  = '{1, 0, 45, 1, 175, 43, 1};
    tbl[7]  = '{1, 0, 45, 1, 180, 45, 1};
    tbl[8]  = '{0, 0, 7,  0, 180, 45, 1};
    tbl[9]  = '{0, 0, 9,  0, 180, 45, 1};
    tbl[10] = '{0, 0, 11, 0, 180, 45, 1};
    tbl[11] = '{1, 0, 0,  1, 135, 33, 1};
    tbl[12] = '{1, 1, 45, 0, 0,   0,  0};
    tbl[13] = '{1, 0, 1,  0, 1,   0,  0};
    tbl[14] = '{1, 0, 1,  0, 2,   0,  0};
    tbl[15] = '{1, 0, 1,  0, 3,   0,  0};
    tbl[16] = '{1, 0, 1,  1, 4,   1,  1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    in_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum",   int'(out_sum),   0);
    chk("rst_out_avg",   int'(out_avg),   0);
    chk("rst_full",      int'(full),      0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].c, int'(tbl[i].d));
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_sum", i),   int'(out_sum),   tbl[i].es);
      chk($sformatf("tbl%0d_avg", i),   int'(out_avg),   tbl[i].ea);
      chk($sformatf("tbl%0d_full", i),  int'(full),      int'(tbl[i].ef));
    end

    // Asynchronous reset between edges, then refill from empty.
    step(1, 0, 30);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_sum",   int'(out_sum),   0);
    chk("async_rst_avg",   int'(out_avg),   0);
    chk("async_rst_full",  int'(full),      0);
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 5);
      chk("refill_full_low", int'(full), 0);
    end
    step(1, 0, 5);
    chk("refill_valid", int'(out_valid), 1);
    chk("refill_sum",   int'(out_sum),   20);
    chk("refill_avg",   int'(out_avg),   5);
    chk("refill_full",  int'(full),      1);

    // Random sums from a three-operand adder with sparse valid and rare clear.
    for (int i = 0; i < 400; i++) begin
      int a, b, c;
      bit v, cl;
      a  = $urandom_range(15);
      b  = $urandom_range(15);
      c  = $urandom_range(15);
      v  = ($urandom_range(3) != 0);
      cl = ($urandom_range(40) == 0);
      step(v, cl, a + b + c);
    end
    step(0, 0, 0);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
